// File: rtl/router_fifo_if.sv
// Handshake bundle between the router write side/output port and one router_fifo.
// The master side issues writes and reads; the slave (the FIFO) reports data and status.
interface router_fifo_if #(
    parameter int WIDTH = 8
);
    logic             write_enb;
    logic             read_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             pkt_active;

    modport master (
        output write_enb, read_enb, lfd_state, data_in,
        input  data_out, full, empty, pkt_active
    );

    modport slave (
        input  write_enb, read_enb, lfd_state, data_in,
        output data_out, full, empty, pkt_active
    );
endinterface

// File: rtl/router_fifo.sv
// Per-port packet FIFO for the router: stores bytes tagged with a header flag and
// tracks how many bytes of the current packet remain to be read out.
module router_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input logic          clock,
    input logic          reset,
    input logic          soft_reset,
    router_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, ACTIVE} pkt_state_t;

    logic [WIDTH:0] mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [5:0]     count;
    pkt_state_t     state;

    logic           write_ok;
    logic           read_ok;
    logic [WIDTH:0] rd_entry;
    logic [5:0]     header_len;

    // One extra pointer bit separates the full and empty cases when the low bits match.
    assign bus.empty = (wr_ptr == rd_ptr);
    assign bus.full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign write_ok   = bus.write_enb && !bus.full;
    assign read_ok    = bus.read_enb && !bus.empty;
    assign rd_entry   = mem[rd_ptr[AW-1:0]];
    assign header_len = rd_entry[7:2] + 6'd1;

    assign bus.pkt_active = (state == ACTIVE);

    always_ff @(posedge clock) begin
        if (write_ok && !soft_reset) begin
            mem[wr_ptr[AW-1:0]] <= {bus.lfd_state, bus.data_in};
        end
    end

    // A header reload always wins, so a truncated packet is simply abandoned.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            bus.data_out <= '0;
            count        <= '0;
            state        <= IDLE;
        end else if (soft_reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            bus.data_out <= '0;
            count        <= '0;
            state        <= IDLE;
        end else begin
            if (write_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (read_ok) begin
                rd_ptr       <= rd_ptr + 1'b1;
                bus.data_out <= rd_entry[WIDTH-1:0];
                if (rd_entry[WIDTH]) begin
                    count <= header_len;
                    state <= (header_len != 6'd0) ? ACTIVE : IDLE;
                end else if (count != 6'd0) begin
                    count <= count - 6'd1;
                    if (count == 6'd1) begin
                        state <= IDLE;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_router_fifo.sv
// Scoreboard bench for router_fifo: a queue model predicts stored bytes, read data,
// full/empty and the packet-active flag, and every result is compared against it.
module tb_router_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic clock = 1'b0;
    logic reset;
    logic soft_reset;

    router_fifo_if #(.WIDTH(WIDTH)) bus ();

    router_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] model_q[$];
    logic [7:0] exp_q[$];
    logic [5:0] model_cnt;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        exp_q.delete();
        model_cnt = 6'd0;
    endtask

    // One clock of stimulus; status is checked before the edge, results after it.
    task automatic applyStimulus(input logic wr, input logic rd, input logic lfd, input logic [7:0] din);
        bit         exp_full;
        bit         exp_empty;
        bit         rd_ok;
        bit         wr_ok;
        logic [8:0] e;
        exp_full  = (model_q.size() == DEPTH);
        exp_empty = (model_q.size() == 0);
        checkOutput("full", bus.full, exp_full);
        checkOutput("empty", bus.empty, exp_empty);
        bus.write_enb = wr;
        bus.read_enb  = rd;
        bus.lfd_state = lfd;
        bus.data_in   = din;
        @(posedge clock);
        #1;
        rd_ok = rd && !exp_empty;
        wr_ok = wr && !exp_full;
        if (rd_ok) begin
            e = model_q.pop_front();
            exp_q.push_back(e[7:0]);
            if (e[8]) model_cnt = e[7:2] + 6'd1;
            else if (model_cnt != 6'd0) model_cnt = model_cnt - 6'd1;
        end
        if (wr_ok) model_q.push_back({lfd, din});
        if (rd_ok) checkOutput("data_out", bus.data_out, exp_q.pop_front());
        checkOutput("pkt_active", bus.pkt_active, model_cnt != 6'd0);
        bus.write_enb = 1'b0;
        bus.read_enb  = 1'b0;
        bus.lfd_state = 1'b0;
    endtask

    task automatic applyFlush();
        bus.read_enb  = 1'b1;
        bus.write_enb = 1'b1;
        bus.data_in   = 8'hEE;
        soft_reset    = 1'b1;
        @(posedge clock);
        #1;
        soft_reset    = 1'b0;
        bus.read_enb  = 1'b0;
        bus.write_enb = 1'b0;
        modelReset();
        checkOutput("flush_empty", bus.empty, 1'b1);
        checkOutput("flush_full", bus.full, 1'b0);
        checkOutput("flush_pkt_active", bus.pkt_active, 1'b0);
        checkOutput("flush_data_out", bus.data_out, 8'h00);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_empty"}, bus.empty, 1'b1);
        checkOutput({tag, "_full"}, bus.full, 1'b0);
        checkOutput({tag, "_data_out"}, bus.data_out, 8'h00);
        checkOutput({tag, "_pkt_active"}, bus.pkt_active, 1'b0);
    endtask

    initial begin
        reset         = 1'b1;
        soft_reset    = 1'b0;
        bus.write_enb = 1'b0;
        bus.read_enb  = 1'b0;
        bus.lfd_state = 1'b0;
        bus.data_in   = '0;
        modelReset();

        // Reset must act before any clock edge has occurred.
        #2;
        checkResetOutputs("reset_no_edge");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checkResetOutputs("reset_idle");

        $display("[TB] packet write/read");
        applyStimulus(1, 0, 1, 8'h0C);
        applyStimulus(1, 0, 0, 8'hA1);
        applyStimulus(1, 0, 0, 8'hA2);
        applyStimulus(1, 0, 0, 8'hA3);
        applyStimulus(1, 0, 0, 8'h55);
        applyStimulus(0, 1, 0, 8'h00);
        checkOutput("pkt_after_header", bus.pkt_active, 1'b1);
        repeat (4) applyStimulus(0, 1, 0, 8'h00);
        checkOutput("pkt_after_parity", bus.pkt_active, 1'b0);
        checkOutput("pkt_end_empty", bus.empty, 1'b1);

        $display("[TB] full boundary");
        for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 8'(i));
        checkOutput("full_after_16", bus.full, 1'b1);
        applyStimulus(1, 0, 0, 8'hFF);
        for (int i = 0; i < 16; i++) applyStimulus(0, 1, 0, 8'h00);
        checkOutput("empty_after_drain", bus.empty, 1'b1);

        $display("[TB] simultaneous read/write");
        for (int i = 0; i < 15; i++) applyStimulus(1, 0, 0, 8'(8'h20 + i));
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 8'(8'h40 + i));
        checkOutput("simul_not_full", bus.full, 1'b0);
        applyStimulus(1, 0, 0, 8'h50);
        checkOutput("simul_full_16", bus.full, 1'b1);
        applyStimulus(1, 1, 0, 8'h51);
        checkOutput("simul_read_only", bus.full, 1'b0);
        for (int i = 0; i < 15; i++) applyStimulus(0, 1, 0, 8'h00);
        checkOutput("simul_drained", bus.empty, 1'b1);

        $display("[TB] wrap-around");
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 10; k++) applyStimulus(1, 0, 0, 8'($urandom_range(0, 255)));
            for (int k = 0; k < 10; k++) applyStimulus(0, 1, 0, 8'h00);
        end
        checkOutput("wrap_empty", bus.empty, 1'b1);

        $display("[TB] soft reset flush");
        applyStimulus(1, 0, 1, 8'h0C);
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 8'(8'hB0 + i));
        applyStimulus(0, 1, 0, 8'h00);
        checkOutput("flush_pre_active", bus.pkt_active, 1'b1);
        applyFlush();
        applyStimulus(1, 0, 0, 8'h3C);
        applyStimulus(0, 1, 0, 8'h00);

        $display("[TB] asynchronous reset mid-packet");
        applyStimulus(1, 0, 1, 8'h10);
        applyStimulus(1, 0, 0, 8'hC1);
        applyStimulus(1, 0, 0, 8'hC2);
        applyStimulus(0, 1, 0, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkResetOutputs("reset_async");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(1, 0, 0, 8'h77);
        applyStimulus(0, 1, 0, 8'h00);
        checkOutput("reset_final_empty", bus.empty, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
